// File: rtl/cache_way_read_pipe_pkg.sv
// Shared cache read-path constants and the stage payload type.
package cache_pkg;

  localparam int unsigned CACHE_WAYS    = 8;
  localparam int unsigned CACHE_BLOCK_W = 256;
  localparam int unsigned CACHE_WORD_W  = 32;
  localparam int unsigned CACHE_SEL_W   = $clog2(CACHE_WAYS);
  localparam int unsigned CACHE_OFF_W   = $clog2(CACHE_BLOCK_W / CACHE_WORD_W);

  // Payload carried by one pipeline stage at the default geometry.
  typedef struct packed {
    logic                     hit;
    logic                     multi_hit;
    logic [CACHE_SEL_W-1:0]   way;
    logic [CACHE_BLOCK_W-1:0] blk;
    logic [CACHE_OFF_W-1:0]   off;
  } cache_stage_t;

endpackage

// File: rtl/cache_way_read_pipe_hit_prio_enc.sv
// Lowest-index priority encoder for a tag-compare hit vector.
module cache_hit_prio_enc
  import cache_pkg::*;
#(
  parameter  int unsigned WAYS  = CACHE_WAYS,
  localparam int unsigned SEL_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  hit_vec,
  output logic [SEL_W-1:0] way,
  output logic             hit,
  output logic             multi_hit
);

  logic found;

  // Scan upward: the first set bit wins, any later set bit marks a multi-hit.
  always_comb begin
    way       = '0;
    found     = 1'b0;
    multi_hit = 1'b0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (hit_vec[i]) begin
        if (!found) begin
          way   = SEL_W'(i);
          found = 1'b1;
        end else begin
          multi_hit = 1'b1;
        end
      end
    end
    hit = found;
  end

endmodule

// File: rtl/cache_way_read_pipe.sv
// Two-stage valid/ready way select with word extract and hit/miss statistics.
module cache_way_read_pipe
  import cache_pkg::*;
#(
  parameter  int unsigned WAYS    = CACHE_WAYS,
  parameter  int unsigned BLOCK_W = CACHE_BLOCK_W,
  parameter  int unsigned WORD_W  = CACHE_WORD_W,
  parameter  int unsigned CNT_W   = 32,
  localparam int unsigned SEL_W   = $clog2(WAYS),
  localparam int unsigned OFF_W   = $clog2(BLOCK_W / WORD_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WAYS*BLOCK_W-1:0] way_blocks,
  input  logic [WAYS-1:0]         hit_vec,
  input  logic [OFF_W-1:0]        word_off,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_W-1:0]      out_block,
  output logic [WORD_W-1:0]       out_word,
  output logic                    out_hit,
  output logic [SEL_W-1:0]        out_way,
  output logic                    out_multi_hit,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic [CNT_W-1:0]        miss_cnt
);

  localparam int unsigned NWORDS = BLOCK_W / WORD_W;

  typedef struct packed {
    logic               hit;
    logic               multi_hit;
    logic [SEL_W-1:0]   way;
    logic [BLOCK_W-1:0] blk;
    logic [OFF_W-1:0]   off;
  } s1_t;

  typedef struct packed {
    logic               hit;
    logic               multi_hit;
    logic [SEL_W-1:0]   way;
    logic [BLOCK_W-1:0] blk;
    logic [WORD_W-1:0]  word;
  } s2_t;

  logic [SEL_W-1:0]   enc_way;
  logic               enc_hit;
  logic               enc_multi;
  logic [BLOCK_W-1:0] sel_blk;
  logic [WORD_W-1:0]  s1_word;
  logic               s1_adv;
  logic               s2_adv;
  logic               accept;

  logic               s1_valid_q, s1_valid_d;
  logic               s2_valid_q, s2_valid_d;
  s1_t                s1_q, s1_d;
  s2_t                s2_q, s2_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  cache_hit_prio_enc #(.WAYS(WAYS)) u_enc (
    .hit_vec   (hit_vec),
    .way       (enc_way),
    .hit       (enc_hit),
    .multi_hit (enc_multi)
  );

  // Handshake: a stage advances when empty or when its downstream advances.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
    accept   = in_valid && s1_adv;
  end

  // Select the winning way's block; a miss yields an all-zero block.
  always_comb begin
    sel_blk = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (enc_hit && (enc_way == SEL_W'(i))) begin
        sel_blk = way_blocks[i*BLOCK_W +: BLOCK_W];
      end
    end
  end

  // Extract the addressed word from the block held in stage 1.
  always_comb begin
    s1_word = '0;
    for (int unsigned j = 0; j < NWORDS; j++) begin
      if (s1_q.off == OFF_W'(j)) begin
        s1_word = s1_q.blk[j*WORD_W +: WORD_W];
      end
    end
  end

  // Stage 1 next state: load on advance, hold otherwise.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d = '{hit: enc_hit, multi_hit: enc_multi, way: enc_way,
                 blk: sel_blk, off: word_off};
      end
    end
  end

  // Stage 2 next state: an empty stage 1 passes a bubble.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d = '{hit: s1_q.hit, multi_hit: s1_q.multi_hit, way: s1_q.way,
                 blk: s1_q.blk, word: s1_word};
      end
    end
  end

  // Saturating statistics; clear wins over a same-cycle acceptance.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (cnt_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (accept) begin
      if (enc_hit) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_block     = s2_q.blk;
  assign out_word      = s2_q.word;
  assign out_hit       = s2_q.hit;
  assign out_way       = s2_q.way;
  assign out_multi_hit = s2_q.multi_hit;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_cache_way_read_pipe.sv
// Scoreboard bench for cache_way_read_pipe: driver queues expectations, monitor checks outputs.
module tb_cache_way_read_pipe;

  localparam int W  = 8;
  localparam int BW = 256;
  localparam int WW = 32;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W*BW-1:0] way_blocks;
  logic [W-1:0]    hit_vec;
  logic [2:0]      word_off;
  logic            out_valid;
  logic            out_ready;
  logic [BW-1:0]   out_block;
  logic [WW-1:0]   out_word;
  logic            out_hit;
  logic [2:0]      out_way;
  logic            out_multi_hit;
  logic            cnt_clr;
  logic [CW-1:0]   hit_cnt;
  logic [CW-1:0]   miss_cnt;

  cache_way_read_pipe #(.WAYS(W), .BLOCK_W(BW), .WORD_W(WW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .way_blocks    (way_blocks),
    .hit_vec       (hit_vec),
    .word_off      (word_off),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_block     (out_block),
    .out_word      (out_word),
    .out_hit       (out_hit),
    .out_way       (out_way),
    .out_multi_hit (out_multi_hit),
    .cnt_clr       (cnt_clr),
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          hit;
    logic          multi;
    logic [2:0]    way;
    logic [BW-1:0] blk;
    logic [WW-1:0] word;
  } res_t;

  res_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   stall_lo = 0;
  int   stall_hi = 0;
  bit   saw_bp;
  bit   held = 1'b0;
  res_t snap;

  always @(posedge clk) cyc <= cyc + 1;

  // Word j of way i: {seed, i, j, C3}.
  function automatic logic [WW-1:0] pat(input logic [15:0] seed, input int i, input int j);
    return {seed, 4'(i), 4'(j), 8'hC3};
  endfunction

  function automatic logic [W*BW-1:0] mk(input logic [15:0] seed);
    logic [W*BW-1:0] b;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < BW/WW; j++)
        b[i*BW + j*WW +: WW] = pat(seed, i, j);
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ready();
    out_ready = !(cyc >= stall_lo && cyc < stall_hi);
  endtask

  task automatic send(input logic [W-1:0] hv, input logic [2:0] off, input logic [W*BW-1:0] bl,
                      input logic eh, input logic em, input logic [2:0] ew,
                      input logic [WW-1:0] eword, input logic clr = 1'b0);
    res_t r;
    bit   done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      in_valid   = 1'b1;
      hit_vec    = hv;
      word_off   = off;
      way_blocks = bl;
      cnt_clr    = clr;
      set_ready();
      #1;
      if (in_ready) begin
        r.hit   = eh;
        r.multi = em;
        r.way   = ew;
        r.blk   = eh ? bl[int'(ew)*BW +: BW] : '0;
        r.word  = eword;
        exp_q.push_back(r);
        done = 1'b1;
      end else begin
        saw_bp = 1'b1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected acceptance");
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    set_ready();
  endtask

  task automatic clr_cnt();
    @(negedge clk);
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    set_ready();
  endtask

  task automatic drain(input int bound);
    for (int k = 0; k < bound && exp_q.size() != 0; k++) begin
      idle();
      #3;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: checks stall stability and pops one expectation per output transfer.
  always @(negedge clk) begin
    res_t cur;
    res_t e;
    #2;
    cur = '{hit: out_hit, multi: out_multi_hit, way: out_way, blk: out_block, word: out_word};
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        tests++;
        if (!out_valid || cur !== snap) begin
          fails++;
          $display("FAIL stall_hold: got v=%0b %h expected v=1 %h", out_valid, cur, snap);
        end
      end
      if (out_valid && !out_ready) begin
        held = 1'b1;
        snap = cur;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: got %h expected no output", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            fails++;
            $display("FAIL result: got hit=%0b multi=%0b way=%0d word=%h blk=%h expected hit=%0b multi=%0b way=%0d word=%h blk=%h",
                     cur.hit, cur.multi, cur.way, cur.word, cur.blk,
                     e.hit, e.multi, e.way, e.word, e.blk);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W*BW-1:0] bl;
    rst = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    hit_vec = '0; word_off = '0; way_blocks = '0; saw_bp = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
    check("rst_out_fields", {59'd0, |out_block, |out_word, out_hit, |out_way, out_multi_hit}, 64'd0);

    // Single hit on way 2, two-cycle latency.
    bl = mk(16'h0001);
    bl[2*BW +: WW] = 32'hDEADBEEF;
    send(8'b0000_0100, 3'd0, bl, 1'b1, 1'b0, 3'd2, 32'hDEADBEEF);
    idle(); #1;
    check("latency_cycle1", 64'(out_valid), 64'd0);
    idle(); #1;
    check("latency_cycle2", 64'(out_valid), 64'd1);
    drain(5);
    check("t1_hit_cnt", 64'(hit_cnt), 64'd1);
    check("t1_miss_cnt", 64'(miss_cnt), 64'd0);

    // Multi-hit then miss.
    clr_cnt();
    bl = mk(16'h1111);
    send(8'b1010_0000, 3'd3, bl, 1'b1, 1'b1, 3'd5, 32'h1111_53C3);
    send(8'b0000_0000, 3'd1, bl, 1'b0, 1'b0, 3'd0, 32'h0);
    drain(10);
    check("t2_hit_cnt", 64'(hit_cnt), 64'd1);
    check("t2_miss_cnt", 64'(miss_cnt), 64'd1);

    // Backpressure: out_ready low for 3 cycles mid-stream.
    clr_cnt();
    bl = mk(16'h2222);
    saw_bp = 1'b0;
    stall_lo = cyc + 3;
    stall_hi = cyc + 6;
    send(8'b0000_0010, 3'd0, bl, 1'b1, 1'b0, 3'd1, 32'h2222_10C3);
    send(8'b0000_0001, 3'd1, bl, 1'b1, 1'b0, 3'd0, 32'h2222_01C3);
    send(8'b0000_1000, 3'd2, bl, 1'b1, 1'b0, 3'd3, 32'h2222_32C3);
    send(8'b1000_0000, 3'd3, bl, 1'b1, 1'b0, 3'd7, 32'h2222_73C3);
    send(8'b1100_0000, 3'd4, bl, 1'b1, 1'b1, 3'd6, 32'h2222_64C3);
    send(8'b0001_0000, 3'd5, bl, 1'b1, 1'b0, 3'd4, 32'h2222_45C3);
    drain(20);
    check("t3_in_ready_dropped", 64'(saw_bp), 64'd1);
    check("t3_hit_cnt", 64'(hit_cnt), 64'd6);
    check("t3_miss_cnt", 64'(miss_cnt), 64'd0);

    // Word offset sweep on way 7.
    clr_cnt();
    bl = mk(16'h3333);
    for (int j = 0; j < 8; j++)
      send(8'b1000_0000, 3'(j), bl, 1'b1, 1'b0, 3'd7, {16'h3333, 4'h7, 4'(j), 8'hC3});
    drain(20);
    check("t4_hit_cnt", 64'(hit_cnt), 64'd8);

    // Saturation at 15, then clear coinciding with an accepted miss.
    clr_cnt();
    bl = mk(16'h4444);
    for (int k = 0; k < 17; k++)
      send(8'b0000_0001, 3'd0, bl, 1'b1, 1'b0, 3'd0, 32'h4444_00C3);
    send(8'b0000_0000, 3'd6, bl, 1'b0, 1'b0, 3'd0, 32'h0);
    drain(20);
    check("t5_hit_sat", 64'(hit_cnt), 64'd15);
    check("t5_miss_one", 64'(miss_cnt), 64'd1);
    send(8'b0000_0000, 3'd2, bl, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1);
    drain(10);
    check("t5_clr_hit", 64'(hit_cnt), 64'd0);
    check("t5_clr_miss", 64'(miss_cnt), 64'd0);

    // Reset with both stages full.
    clr_cnt();
    bl = mk(16'h5555);
    stall_lo = cyc;
    stall_hi = cyc + 1000;
    send(8'b0000_1000, 3'd1, bl, 1'b1, 1'b0, 3'd3, 32'h5555_31C3);
    send(8'b0100_0000, 3'd2, bl, 1'b1, 1'b0, 3'd6, 32'h5555_62C3);
    idle(); #1;
    check("t6_full_valid", 64'(out_valid), 64'd1);
    check("t6_full_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    stall_hi = 0;
    out_ready = 1'b1;
    #1;
    check("t6_rst_out_valid", 64'(out_valid), 64'd0);
    check("t6_rst_hit_cnt", 64'(hit_cnt), 64'd0);
    check("t6_rst_miss_cnt", 64'(miss_cnt), 64'd0);
    check("t6_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (5) idle();
    send(8'b0000_0010, 3'd4, bl, 1'b1, 1'b0, 3'd1, 32'h5555_14C3);
    drain(10);
    check("t6_post_hit_cnt", 64'(hit_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_way_read_pipe.md
Name: cache_way_read_pipe

Overview:
- Parametrised successor to the 8-way, 256-bit block select used on the cache read path.
- Takes every way's block together with a one-hot hit vector from tag compare, and encodes the hit way with lowest-index priority.
- Returns the selected block and one word within it through a 2-stage, valid/ready pipeline.
- Flags miss and multi-hit, and keeps saturating hit/miss statistics counters.

Parameters:
WAYS, 8, number of ways; must be a power of two and at least 2
BLOCK_W, 256, block width in bits
WORD_W, 32, word width; BLOCK_W must be a multiple of WORD_W
SEL_W, $clog2(WAYS), derived way-index width; not overridden
OFF_W, $clog2(BLOCK_W/WORD_W), derived word-offset width; not overridden
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
way_blocks  in  WAYS*BLOCK_W  way i occupies bits [i*BLOCK_W +: BLOCK_W]
hit_vec  in  WAYS  per-way tag-match result
word_off  in  OFF_W  word index within the block
out_valid  out  1  result valid
out_ready  in  1  consumer accepts when out_valid && out_ready
out_block  out  BLOCK_W  selected block; 0 on miss
out_word  out  WORD_W  out_block[word_off*WORD_W +: WORD_W]; 0 on miss
out_hit  out  1  hit_vec had at least one bit set
out_way  out  SEL_W  lowest set index of hit_vec; 0 on miss
out_multi_hit  out  1  more than one bit of hit_vec set
cnt_clr  in  1  synchronous clear of both counters
hit_cnt  out  CNT_W  accepted hits, saturating
miss_cnt  out  CNT_W  accepted misses, saturating

Behaviour:
- Reset: the synchronous, active-high rst drives all of the following to 0 on the next clk edge: s1_valid, s2_valid, out_valid, every out_* data field, hit_cnt and miss_cnt. rst has priority over every other input. In-flight requests are dropped. in_ready is 1 in the cycle after reset.
- Stage 1 (S1) registers:
  - way index, from the lowest-index priority encode of hit_vec;
  - hit, as the OR-reduce of hit_vec;
  - multi_hit, set when more than one bit of hit_vec is set;
  - the selected block (0 on miss);
  - word_off.
- Stage 2 (S2) registers the word slice of the S1 block, plus the S1 block, way, hit and multi_hit. S2 drives the out_* ports directly from its registers.
- Latency: exactly 2 cycles from acceptance to out_valid when there is no stall. Throughput is 1 request per cycle.
- Handshake:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv, a combinational path from out_ready.
- A stall holds every S1 and S2 register stable. out_* must not change while out_valid=1 and out_ready=0.
- Bubbles: when S1 is empty and s2_adv=1, S2 loads valid=0.
- Accepted requests are never dropped or duplicated.
- Miss (hit_vec == 0): out_hit=0, out_way=0, out_block=0, out_word=0, out_multi_hit=0.
- Multi-hit: the lowest set index wins and out_multi_hit=1. Data comes from that way. It counts as one hit.
- Counters:
  - Each counter updates in the cycle of acceptance (in_valid && in_ready): hit_cnt increments on a hit, miss_cnt increments on a miss.
  - Each counter saturates at all-ones and does not wrap.
  - cnt_clr has priority over a simultaneous acceptance. Both counters become 0 and that event is not counted.
  - Counters are not affected by output stalls.
- word_off is used only with the block it arrived with. There is no cross-request mixing.

Decomposition:
- Shared package cache_pkg holds:
  - default constants CACHE_WAYS=8, CACHE_BLOCK_W=256, CACHE_WORD_W=32;
  - a stage payload struct typedef {logic hit; logic multi_hit; logic [SEL_W-1:0] way; logic [BLOCK_W-1:0] blk; logic [OFF_W-1:0] off;}, sized from the package defaults.
- One sub-module: cache_hit_prio_enc, parametrised on WAYS. It is combinational and produces way, hit and multi_hit from hit_vec. It is reused by the tag-compare stage.
- Block select, word slice, pipeline registers and counters stay in cache_way_read_pipe.

Test Plan:
- Single request, defaults, out_ready=1: hit_vec=8'b0000_0100, way2 block=0x…DEAD_BEEF in word 0, word_off=0 -> 2 cycles later out_valid=1, out_way=2, out_hit=1, out_word=0xDEADBEEF, out_block equals way2, hit_cnt=1.
- Multi-hit and miss back-to-back: hit_vec=8'b1010_0000, then 8'b0 -> first result has out_way=5 and out_multi_hit=1. Second has out_hit=0 and out_block=0, out_word=0, out_way=0, out_multi_hit=0. hit_cnt=1, miss_cnt=1.
- Backpressure: stream 6 requests with in_valid=1 and out_ready low for 3 cycles mid-stream -> in_ready drops after S1 and S2 fill. out_* stay stable while stalled. All 6 results emerge in order with no loss or duplication.
- Word-offset sweep: word_off=0..7 with distinct per-word patterns in way 7 -> out_word matches each slice. Also cover word_off=7 (top word).
- Counter saturation and clear: CNT_W=4, 17 hits -> hit_cnt=15. Assert cnt_clr in the same cycle as an accepted miss -> miss_cnt=0 and hit_cnt=0.
- Reset mid-operation: assert rst with both stages valid -> next cycle out_valid=0 and counters=0. in_ready=1 after rst deasserts, and no stale output appears.
